// File: rtl/common_pkg.sv
// Shared RV32I encoding types: operation enum, opcode/funct constants and the NOP word.
// The per-op decode table lives here so the packer and any future decoder agree on it.
package common;

  typedef logic [31:0] instruction_type;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  } op_type;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam instruction_type NOP = 32'h0000_0013;

  typedef struct packed {
    fmt_type    fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_info_type;

  // Any op_type encoding outside the 37 defined ops decodes to FMT_BAD.
  function automatic op_info_type decode_op(input op_type op);
    op_info_type d;
    d = '{FMT_BAD, 7'd0, 3'd0, F7_BASE};
    case (op)
      OP_ADD:   d = '{FMT_R,  OPC_OP,     F3_ADD,  F7_BASE};
      OP_SUB:   d = '{FMT_R,  OPC_OP,     F3_ADD,  F7_ALT};
      OP_SLL:   d = '{FMT_R,  OPC_OP,     F3_SLL,  F7_BASE};
      OP_SLT:   d = '{FMT_R,  OPC_OP,     F3_SLT,  F7_BASE};
      OP_SLTU:  d = '{FMT_R,  OPC_OP,     F3_SLTU, F7_BASE};
      OP_XOR:   d = '{FMT_R,  OPC_OP,     F3_XOR,  F7_BASE};
      OP_SRL:   d = '{FMT_R,  OPC_OP,     F3_SR,   F7_BASE};
      OP_SRA:   d = '{FMT_R,  OPC_OP,     F3_SR,   F7_ALT};
      OP_OR:    d = '{FMT_R,  OPC_OP,     F3_OR,   F7_BASE};
      OP_AND:   d = '{FMT_R,  OPC_OP,     F3_AND,  F7_BASE};
      OP_ADDI:  d = '{FMT_I,  OPC_OPIMM,  F3_ADD,  F7_BASE};
      OP_SLTI:  d = '{FMT_I,  OPC_OPIMM,  F3_SLT,  F7_BASE};
      OP_SLTIU: d = '{FMT_I,  OPC_OPIMM,  F3_SLTU, F7_BASE};
      OP_XORI:  d = '{FMT_I,  OPC_OPIMM,  F3_XOR,  F7_BASE};
      OP_ORI:   d = '{FMT_I,  OPC_OPIMM,  F3_OR,   F7_BASE};
      OP_ANDI:  d = '{FMT_I,  OPC_OPIMM,  F3_AND,  F7_BASE};
      OP_SLLI:  d = '{FMT_SH, OPC_OPIMM,  F3_SLL,  F7_BASE};
      OP_SRLI:  d = '{FMT_SH, OPC_OPIMM,  F3_SR,   F7_BASE};
      OP_SRAI:  d = '{FMT_SH, OPC_OPIMM,  F3_SR,   F7_ALT};
      OP_LB:    d = '{FMT_I,  OPC_LOAD,   F3_B,    F7_BASE};
      OP_LH:    d = '{FMT_I,  OPC_LOAD,   F3_H,    F7_BASE};
      OP_LW:    d = '{FMT_I,  OPC_LOAD,   F3_W,    F7_BASE};
      OP_LBU:   d = '{FMT_I,  OPC_LOAD,   F3_BU,   F7_BASE};
      OP_LHU:   d = '{FMT_I,  OPC_LOAD,   F3_HU,   F7_BASE};
      OP_SB:    d = '{FMT_S,  OPC_STORE,  F3_B,    F7_BASE};
      OP_SH:    d = '{FMT_S,  OPC_STORE,  F3_H,    F7_BASE};
      OP_SW:    d = '{FMT_S,  OPC_STORE,  F3_W,    F7_BASE};
      OP_BEQ:   d = '{FMT_B,  OPC_BRANCH, F3_BEQ,  F7_BASE};
      OP_BNE:   d = '{FMT_B,  OPC_BRANCH, F3_BNE,  F7_BASE};
      OP_BLT:   d = '{FMT_B,  OPC_BRANCH, F3_BLT,  F7_BASE};
      OP_BGE:   d = '{FMT_B,  OPC_BRANCH, F3_BGE,  F7_BASE};
      OP_BLTU:  d = '{FMT_B,  OPC_BRANCH, F3_BLTU, F7_BASE};
      OP_BGEU:  d = '{FMT_B,  OPC_BRANCH, F3_BGEU, F7_BASE};
      OP_JAL:   d = '{FMT_J,  OPC_JAL,    3'd0,    F7_BASE};
      OP_JALR:  d = '{FMT_I,  OPC_JALR,   3'd0,    F7_BASE};
      OP_LUI:   d = '{FMT_U,  OPC_LUI,    3'd0,    F7_BASE};
      OP_AUIPC: d = '{FMT_U,  OPC_AUIPC,  3'd0,    F7_BASE};
      default:  d = '{FMT_BAD, 7'd0, 3'd0, F7_BASE};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/insn_pack.sv
// Combinational RV32I field packer; failed encodings come out as NOP with error set.
// Optional macro IMM_RANGE_CHECK_EN turns out-of-range immediates into failures instead of truncating.
module insn_pack
  import common::*;
(
  input  op_type          op,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [31:0]     imm,
  output instruction_type instr,
  output logic            error
);

  op_info_type     info;
  instruction_type raw;
  logic            imm_bad;

  assign info = decode_op(op);

  always_comb begin
    raw = '0;
    case (info.fmt)
      FMT_R:   raw = {info.funct7, rs2, rs1, info.funct3, rd, info.opcode};
      FMT_I:   raw = {imm[11:0], rs1, info.funct3, rd, info.opcode};
      FMT_SH:  raw = {info.funct7, imm[4:0], rs1, info.funct3, rd, info.opcode};
      FMT_S:   raw = {imm[11:5], rs2, rs1, info.funct3, imm[4:0], info.opcode};
      FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, info.funct3, imm[4:1], imm[11], info.opcode};
      FMT_U:   raw = {imm[31:12], rd, info.opcode};
      FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, info.opcode};
      default: raw = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A signed N-bit fit means every bit from N-1 upward agrees with the sign.
  always_comb begin
    imm_bad = 1'b0;
    case (info.fmt)
      FMT_I, FMT_S: imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_SH:       imm_bad = |imm[31:5];
      FMT_B:        imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        imm_bad = |imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign error = (info.fmt == FMT_BAD) || imm_bad;
  assign instr = error ? NOP : raw;

endmodule

// File: rtl/insn_encoder.sv
// One-entry registered RV32I encoder with valid/ready handshake, beat counter and sticky error.
// Optional macro IMM_RANGE_CHECK_EN (handled in insn_pack) enables immediate range failures.
module insn_encoder
  import common::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  op_type          in_op,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [31:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output instruction_type out_instr,
  output logic            out_error,
  output logic            err_sticky,
  input  logic            err_clear,
  output logic [15:0]     enc_count
);

  typedef enum logic {EMPTY, FULL} state_type;

  state_type       state;
  state_type       state_next;
  logic            accept;
  logic            pack_error;
  instruction_type pack_instr;

  insn_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .instr (pack_instr),
    .error (pack_error)
  );

  // A full slot can still accept when the consumer drains it in the same cycle.
  assign in_ready  = (state == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_instr <= '0;
      out_error <= 1'b0;
    end else if (accept) begin
      out_instr <= pack_instr;
      out_error <= pack_error;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   enc_count <= 16'd0;
    else if (out_valid & out_ready) enc_count <= enc_count + 16'd1;
  end

  // A failure registered this cycle takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 err_sticky <= 1'b0;
    else if (accept & pack_error) err_sticky <= 1'b1;
    else if (err_clear)           err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard testbench for insn_encoder; expectations follow IMM_RANGE_CHECK_EN when it is defined.
module tb_insn_encoder;
  import common::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  op_type          in_op;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [31:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  instruction_type out_instr;
  logic            out_error;
  logic            err_sticky;
  logic            err_clear;
  logic [15:0]     enc_count;

  typedef struct {
    op_type      op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_count = 16'd0;

  insn_encoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_error  (out_error),
    .err_sticky (err_sticky),
    .err_clear  (err_clear),
    .enc_count  (enc_count)
  );

  always #5 clk = ~clk;

  // Drives one request and records what the DUT must later produce for it.
  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_rd    = v.rd;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_imm   = v.imm;
    exp_q.push_back('{v.instr, v.err});
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_checks++;
    if (out_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_instr: got %h exp 00000000", out_instr); end
    n_checks++;
    if (out_error !== 1'b0 || err_sticky !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_errors: got err %b sticky %b exp 0 0", out_error, err_sticky);
    end
    n_checks++;
    if (enc_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d exp 0", enc_count); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b exp 1", in_ready); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back('{OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0});
    v.push_back('{OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0});
    out_ready = 1'b1;
    for (int i = 0; i <= v.size(); i++) begin
      if (i < v.size()) drive(v[i]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_extra: got word %h exp no word", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_error !== e.err) begin
            n_fail++; $display("[TB] FAIL b2b_word: got %h/%b exp %h/%b", out_instr, out_error, e.instr, e.err);
          end
        end
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 16'd2;
    n_checks++;
    if (enc_count !== 16'd2) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d exp 2", enc_count); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_missing: got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_formats();
    vec_t v[$];
    exp_t e;
    logic [4:0] rd, rs1, rs2;
    v.push_back('{OP_ADDI,  5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b0});
    v.push_back('{OP_SRAI,  5'd1, 5'd1, 5'd0, 32'd3,         32'h4030D093, 1'b0});
    v.push_back('{OP_LUI,   5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0});
    v.push_back('{OP_BEQ,   5'd0, 5'd1, 5'd2, 32'd8,         32'h00208463, 1'b0});
    v.push_back('{OP_BNE,   5'd0, 5'd1, 5'd0, 32'hFFFFFFFC,  32'hFE009EE3, 1'b0});
    v.push_back('{OP_SW,    5'd0, 5'd2, 5'd3, 32'hFFFFFFFC,  32'hFE312E23, 1'b0});
    v.push_back('{OP_LW,    5'd5, 5'd2, 5'd0, 32'd16,        32'h01012283, 1'b0});
    v.push_back('{OP_JAL,   5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0});
    v.push_back('{OP_JALR,  5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067, 1'b0});
    v.push_back('{OP_AUIPC, 5'd1, 5'd0, 5'd0, 32'h00001000,  32'h00001097, 1'b0});
    for (int k = 0; k < 4; k++) begin
      rd  = 5'($urandom_range(31));
      rs1 = 5'($urandom_range(31));
      rs2 = 5'($urandom_range(31));
      v.push_back('{OP_ADD, rd, rs1, rs2, 32'($urandom),
                    (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33, 1'b0});
    end
    out_ready = 1'b1;
    for (int i = 0; i <= v.size(); i++) begin
      if (i < v.size()) drive(v[i]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL fmt_extra: got word %h exp no word", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_error !== e.err) begin
            n_fail++; $display("[TB] FAIL fmt_word: got %h/%b exp %h/%b", out_instr, out_error, e.instr, e.err);
          end
        end
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 16'(v.size());
    n_checks++;
    if (enc_count !== exp_count) begin n_fail++; $display("[TB] FAIL fmt_count: got %0d exp %0d", enc_count, exp_count); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL fmt_missing: got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    drive('{OP_ADDI, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF, 32'hFFF08113, 1'b0});
    @(posedge clk); #1;
    drive('{OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("[TB] FAIL bp_ready: got in_ready %b out_valid %b exp 0 1", in_ready, out_valid);
      end
      n_checks++;
      if (out_instr !== 32'hFFF08113 || out_error !== 1'b0) begin
        n_fail++; $display("[TB] FAIL bp_hold: got %h/%b exp fff08113/0", out_instr, out_error);
      end
      n_checks++;
      if (enc_count !== exp_count) begin n_fail++; $display("[TB] FAIL bp_count: got %0d exp %0d", enc_count, exp_count); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL bp_extra: got word %h exp no word", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_error !== e.err) begin
            n_fail++; $display("[TB] FAIL bp_word: got %h/%b exp %h/%b", out_instr, out_error, e.instr, e.err);
          end
        end
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 16'd2;
    n_checks++;
    if (enc_count !== exp_count) begin n_fail++; $display("[TB] FAIL bp_drain_count: got %0d exp %0d", enc_count, exp_count); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_missing: got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    exp_t e;
    out_ready = 1'b1;
    err_clear = 1'b0;
    drive('{op_type'(6'd45), 5'd1, 5'd2, 5'd3, 32'd0, NOP, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== e.instr || out_error !== e.err) begin
      n_fail++; $display("[TB] FAIL illegal_word: got v%b %h/%b exp v1 %h/%b", out_valid, out_instr, out_error, e.instr, e.err);
    end
    n_checks++;
    if (err_sticky !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_sticky: got %b exp 1", err_sticky); end
    @(posedge clk); #1;
    exp_count = exp_count + 16'd1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_sticky: got %b exp 0", err_sticky); end
    drive('{op_type'(6'd60), 5'd4, 5'd4, 5'd4, 32'd7, NOP, 1'b1});
    err_clear = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    err_clear = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (out_instr !== e.instr || out_error !== e.err) begin
      n_fail++; $display("[TB] FAIL illegal2_word: got %h/%b exp %h/%b", out_instr, out_error, e.instr, e.err);
    end
    n_checks++;
    if (err_sticky !== 1'b1) begin n_fail++; $display("[TB] FAIL set_beats_clear: got %b exp 1", err_sticky); end
    @(posedge clk); #1;
    exp_count = exp_count + 16'd1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  task automatic test_imm_range();
    vec_t v[$];
    exp_t e;
    logic exp_sticky;
`ifdef IMM_RANGE_CHECK_EN
    v.push_back('{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096,     NOP, 1'b1});
    v.push_back('{OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32,       NOP, 1'b1});
    v.push_back('{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,        NOP, 1'b1});
    v.push_back('{OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345678, NOP, 1'b1});
    exp_sticky = 1'b1;
`else
    v.push_back('{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096,     32'h00000093, 1'b0});
    v.push_back('{OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32,       32'h00009093, 1'b0});
    v.push_back('{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,        32'h00208163, 1'b0});
    v.push_back('{OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345678, 32'h123452B7, 1'b0});
    exp_sticky = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i <= v.size(); i++) begin
      if (i < v.size()) drive(v[i]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL imm_extra: got word %h exp no word", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_error !== e.err) begin
            n_fail++; $display("[TB] FAIL imm_word: got %h/%b exp %h/%b", out_instr, out_error, e.instr, e.err);
          end
        end
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 16'(v.size());
    n_checks++;
    if (err_sticky !== exp_sticky) begin n_fail++; $display("[TB] FAIL imm_sticky: got %b exp %b", err_sticky, exp_sticky); end
    n_checks++;
    if (enc_count !== exp_count) begin n_fail++; $display("[TB] FAIL imm_count: got %0d exp %0d", enc_count, exp_count); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL imm_missing: got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive('{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || enc_count !== exp_count) begin
      n_fail++; $display("[TB] FAIL pre_reset_full: got v%b cnt %0d exp v1 cnt %0d", out_valid, enc_count, exp_count);
    end
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_count = 16'd0;
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_error !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_out: got v%b %h/%b exp v0 00000000/0", out_valid, out_instr, out_error);
    end
    n_checks++;
    if (enc_count !== 16'd0) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d exp 0", enc_count); end
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL postreset_idle: got v%b rdy %b exp v0 rdy1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (enc_count !== exp_count) begin n_fail++; $display("[TB] FAIL postreset_count: got %0d exp 0", enc_count); end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_op     = OP_ADD;
    in_rd     = 5'd0;
    in_rs1    = 5'd0;
    in_rs2    = 5'd0;
    in_imm    = 32'd0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    test_reset();
    test_back_to_back();
    test_formats();
    test_backpressure();
    test_illegal();
    test_imm_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have port clk  input  1  single clock, rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port in_valid  input  1  request carries an operation to encode.
REQ-004 SHALL have port in_ready  output  1  encoder accepts the request this cycle.
REQ-005 SHALL have port in_op  input  op_type  RV32I operation, 37 ops (ADD..AND, ADDI..SRAI, LB..LHU, SB..SW, BEQ..BGEU, JAL, JALR, LUI, AUIPC).
REQ-006 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-007 SHALL have port in_imm  input  32  byte-valued immediate; U-type gives the full value, low 12 bits zero.
REQ-008 SHALL have port out_valid  output  1  out_instr holds an encoded word.
REQ-009 SHALL have port out_ready  input  1  consumer takes the word.
REQ-010 SHALL have port out_instr  output  instruction_type  encoded 32-bit word.
REQ-011 SHALL have port out_error  output  1  this beat failed to encode; word is NOP.
REQ-012 SHALL have port err_sticky  output  1  any failure since reset or clear.
REQ-013 SHALL have port err_clear  input  1  clears err_sticky.
REQ-014 SHALL have port enc_count  output  16  beats delivered (out_valid & out_ready), wraps 0xFFFF->0.

Function
REQ-015 SHALL register output: 1-cycle latency from accepted request to out_valid.
REQ-016 SHALL implement FSM EMPTY/FULL: EMPTY->FULL on accept; FULL->EMPTY on out_ready without new accept; FULL->FULL on simultaneous drain and accept.
REQ-017 SHALL drive in_ready = (state==EMPTY) | out_ready, combinationally.
REQ-018 SHALL hold out_instr, out_error stable while out_valid & !out_ready.
REQ-019 SHALL pack fields per RV32I R/I/S/B/U/J formats; opcode and funct3/funct7 derived from in_op; unused fields zero.
REQ-020 SHALL encode SRAI/SUB/SRA with funct7=0100000; shifts use in_imm[4:0] as shamt.
REQ-021 SHALL encode B immediates as imm[12|10:5], imm[4:1|11]; J as imm[20|10:1|11|19:12].
REQ-022 SHALL treat an illegal in_op as failure: out_instr=0x00000013, out_error=1.
REQ-023 SHALL set err_sticky on the cycle a failing word is registered; err_clear in the same cycle loses to the set.
REQ-024 SHALL ignore in_op/in_* when in_valid=0; no state change.

Reset
REQ-025 SHALL on reset_n=0 immediately force state EMPTY, out_valid=0, out_instr=0, out_error=0, err_sticky=0, enc_count=0.
REQ-026 SHALL drop any in-flight word on reset mid-operation; no beat is delivered.

Configuration
REQ-027 SHALL, with IMM_RANGE_CHECK_EN defined, flag failure when in_imm does not fit: I/S signed 12-bit, shamt >31, B signed 13-bit or odd, J signed 21-bit or odd, U low 12 bits nonzero.
REQ-028 SHALL, without IMM_RANGE_CHECK_EN, silently truncate in_imm to the format and never fail on immediates.

Structure
REQ-029 SHALL place op_type enum, opcode/funct constants and NOP constant in package common next to instruction_type.
REQ-030 SHALL use one sub-module insn_pack (combinational field packer); insn_encoder holds FSM, register, counter, error logic.

Verification
REQ-031 SHALL cover ADDI rd=1 rs1=0 imm=5 -> out_instr 0x00500093 one cycle later, out_error=0.
REQ-032 SHALL cover ADD 3,1,2 then SUB 3,1,2 back-to-back with out_ready=1 -> 0x002081B3, 0x402081B3, enc_count=2.
REQ-033 SHALL cover SRAI 1,1,3 -> 0x4030D093; LUI rd=5 imm=0x12345000 -> 0x123452B7; BEQ 1,2,+8 -> 0x00208463.
REQ-034 SHALL cover out_ready=0 for 3 cycles with word held -> in_ready=0, out_instr stable, enc_count unchanged.
REQ-035 SHALL cover ADDI imm=4096 with IMM_RANGE_CHECK_EN -> 0x00000013, out_error=1, err_sticky=1; without it -> 0x00000093.
REQ-036 SHALL cover reset_n pulse while FULL -> out_valid=0 immediately, enc_count=0.
